truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
Sequential exhaustive evaluator that sits directly upstream and downstream of a combinational 7-input Boolean network in the classification flow. It drives every input vector to the network and captures the single-bit response into a 2^N-bit truth table. It also builds a cheap classification signature: onset count plus per-variable positive-cofactor weights. A valid/ready handshake delivers the result to the classifier.

Parameters:
N_IN, 7, number of function inputs; legal range 2..8.
LAT, 0, cycles between driving a vector on x_out and the matching response on f_in; legal range 0..4. 0 means a purely combinational network.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  sweep request; accepted only in IDLE
x_out  output  N_IN  input vector to the network; bit i drives xi
f_in  input  1  network output
busy  output  1  high in DRIVE and DRAIN
res_valid  output  1  result available
res_ready  input  1  consumer accepts the result
tt  output  2^N_IN  truth table; bit v = f(vector v)
onset  output  N_IN+1  popcount of tt
wgt  output  N_IN*N_IN  field i = count of minterms with xi=1 and f=1; each field is N_IN bits wide

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; x_out=0; busy=0; res_valid=0.
  - tt=0; onset=0; all wgt fields=0.
  - Delay line is cleared.
  - Reset mid-sweep abandons the sweep with no partial result.
- States:
  - IDLE to DRIVE on start.
  - DRIVE to DRAIN after vector 2^N-1 is driven.
  - DRAIN to DONE after LAT cycles. When LAT=0, DRAIN lasts 0 cycles and DRIVE goes straight to DONE.
  - DONE to IDLE when res_ready=1.
- Start edge:
  - Clears tt, onset and wgt.
  - Sets x_out=0, a registered output.
- DRIVE:
  - x_out steps through vectors 0..2^N-1, one per cycle.
  - x_out holds its last vector through DRAIN and DONE, then returns to 0 in IDLE.
- Capture:
  - A delay line of depth LAT carries (vector index, valid).
  - A vector driven in cycle c has its f_in sampled at the edge ending cycle c+LAT.
  - On each valid sample with f_in=1: tt[v]=1; onset+1; wgt[i]+1 for every i with v[i]=1.
- Timing: with the start edge as edge 0, res_valid rises at edge 2^N+LAT.
  - Default: edge 128.
  - busy falls at the same edge.
- Output hold: res_valid, tt, onset and wgt are held stable in DONE until res_ready.
  - res_valid and res_ready high together: handshake completes; IDLE next cycle.
  - Results stay readable in IDLE until the next start.
- Ignored start:
  - start in DRIVE, DRAIN or DONE is ignored; no queuing.
  - start in the same cycle as the res_ready handshake is ignored. It must be re-asserted in IDLE.
- Widths, no saturation needed:
  - onset max 2^N needs N+1 bits.
  - wgt max 2^(N-1) fits in N bits.
- f_in is sampled only on valid delay-line slots. X on f_in in other cycles must not corrupt the result.

Optional Feature:
Macro SWEEP_GRAY_EN.
- Defined:
  - Vectors in DRIVE are issued in reflected Gray order: step k drives k^(k>>1).
  - The delay line carries the Gray vector. tt is still indexed by vector value, so the final tt, onset and wgt match binary order.
  - Goal: minimise input toggles.
- Undefined: binary ascending order.
- Timing is identical in both cases.

Test Plan:
- f_in tied 0, default params, start pulse:
  - res_valid at edge 128.
  - tt=0; onset=0; all wgt=0.
- f_in = parity(x_out):
  - onset=64; every wgt field=32.
  - tt bit v = parity(v); e.g. tt[1]=1, tt[3]=0.
- f_in = x0&x1, LAT=2 via two external registers:
  - res_valid at edge 130.
  - onset=32; wgt0=wgt1=32; wgt2..6=16; tt[3]=1, tt[2]=0.
- start re-pulsed at cycles 5 and 129, res_ready held 0:
  - Both pulses ignored; a single result.
  - Results are unchanged after res_ready is asserted.
- rst_n low at cycle 60 mid-sweep, then start:
  - Outputs zero during reset.
  - A fresh full sweep gives a correct result, f_in=x6 giving onset=64, wgt6=64.
- SWEEP_GRAY_EN defined, f_in=x0&x1:
  - x_out sequence is 0,1,3,2,6...
  - Final tt, onset and wgt are identical to the binary run.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector to an external network and builds tt/onset/wgt.
// Optional macro SWEEP_GRAY_EN issues vectors in reflected Gray order instead of binary.
module truth_table_sweeper #(
    parameter int unsigned N_IN = 7,
    parameter int unsigned LAT  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [N_IN-1:0]        x_out,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [(1<<N_IN)-1:0]   tt,
    output logic [N_IN:0]          onset,
    output logic [N_IN*N_IN-1:0]   wgt
);

    localparam int unsigned NV = 1 << N_IN;
    localparam int unsigned OW = N_IN + 1;
    localparam int unsigned LW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

    state_t            state;
    logic [N_IN-1:0]   step;
    logic [LW-1:0]     drain_cnt;
    logic [N_IN-1:0]   step_nxt;
    logic [N_IN-1:0]   vec_nxt;
    logic              cap_vld;
    logic [N_IN-1:0]   cap_vec;
    logic [NV-1:0]     tt_upd;
    logic [N_IN:0]     onset_upd;
    logic [N_IN*N_IN-1:0] wgt_upd;

    assign step_nxt = step + N_IN'(1);

`ifdef SWEEP_GRAY_EN
    assign vec_nxt = step_nxt ^ (step_nxt >> 1);
`else
    assign vec_nxt = step_nxt;
`endif

    // Delay line pairing each driven vector with the f_in sample LAT cycles later
    generate
        if (LAT == 0) begin : g_nodly
            assign cap_vld = (state == DRIVE);
            assign cap_vec = x_out;
        end else begin : g_dly
            logic [N_IN-1:0] dvec [LAT];
            logic [LAT-1:0]  dvld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dvld <= '0;
                    for (int i = 0; i < LAT; i++) dvec[i] <= '0;
                end else begin
                    dvld[0] <= (state == DRIVE);
                    dvec[0] <= x_out;
                    for (int i = 1; i < LAT; i++) begin
                        dvld[i] <= dvld[i-1];
                        dvec[i] <= dvec[i-1];
                    end
                end
            end

            assign cap_vld = dvld[LAT-1];
            assign cap_vec = dvec[LAT-1];
        end
    endgenerate

    // Accumulate one sample; f_in only matters when the slot is valid
    always_comb begin
        tt_upd    = tt;
        onset_upd = onset;
        wgt_upd   = wgt;
        if (cap_vld && f_in) begin
            tt_upd[cap_vec] = 1'b1;
            onset_upd       = onset + OW'(1);
            for (int i = 0; i < N_IN; i++) begin
                if (cap_vec[i]) wgt_upd[i*N_IN +: N_IN] = wgt[i*N_IN +: N_IN] + N_IN'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= '0;
            drain_cnt <= '0;
            x_out     <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            tt        <= '0;
            onset     <= '0;
            wgt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= DRIVE;
                        busy  <= 1'b1;
                        step  <= '0;
                        x_out <= '0;
                        tt    <= '0;
                        onset <= '0;
                        wgt   <= '0;
                    end
                end
                DRIVE: begin
                    tt    <= tt_upd;
                    onset <= onset_upd;
                    wgt   <= wgt_upd;
                    if (step == '1) begin
                        if (LAT == 0) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            res_valid <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end else begin
                        step  <= step_nxt;
                        x_out <= vec_nxt;
                    end
                end
                DRAIN: begin
                    tt    <= tt_upd;
                    onset <= onset_upd;
                    wgt   <= wgt_upd;
                    if (drain_cnt == LW'(LAT - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        res_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + LW'(1);
                    end
                end
                DONE: begin
                    // Results stay readable in IDLE; only the vector returns to zero
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        x_out     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
